// File: rtl/enc_pkg.sv
// Shared definitions for the request-encoder family.
//   MODE_FIXED / MODE_RR : arbitration mode selectors for the MODE parameter.
//   clog2()              : index width for an N-input encoder (minimum 1).
//   popcount_gt1()       : true when more than one bit of a request vector is set.
package enc_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   localparam int MAX_N = 256;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return (r == 0) ? 1 : r;
   endfunction

   // Clearing the lowest set bit leaves something behind only if a second bit
   // was set, which avoids building a full adder tree for the popcount.
   function automatic logic popcount_gt1(input logic [MAX_N-1:0] v);
      return (v & (v - {{(MAX_N-1){1'b0}}, 1'b1})) != '0;
   endfunction

endpackage

// File: rtl/rr_prio_encoder_if.sv
// Request/result bundle for rr_prio_encoder.
//   req       : N-bit request vector (any number of bits set)
//   out_ready : consumer accepts the current result this cycle
//   out_valid : result fields are valid
//   out_idx   : W-bit index of the winner
//   grant     : one-hot of out_idx while out_valid, zero otherwise
//   multi     : more than one request was set when the result was captured
// Modport master belongs to the requester/consumer side, slave to the encoder.
interface rr_prio_encoder_if
   import enc_pkg::*;
#(
   parameter int N = 8
);
   localparam int W = clog2(N);

   logic [N-1:0] req;
   logic         out_ready;
   logic         out_valid;
   logic [W-1:0] out_idx;
   logic [N-1:0] grant;
   logic         multi;

   modport master (output req, out_ready, input out_valid, out_idx, grant, multi);
   modport slave  (input req, out_ready, output out_valid, out_idx, grant, multi);

endinterface

// File: rtl/rr_pick.sv
// Combinational winner search: first set bit of req at or above ptr, wrapping
// to index 0 when nothing is set from ptr upward.
//   req    : N-bit request vector
//   ptr    : W-bit search start position
//   found  : at least one request is set
//   idx    : index of the winner
//   onehot : one-hot of the winner (zero when found is 0)
module rr_pick
   import enc_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0]          req,
   input  logic [clog2(N)-1:0]   ptr,
   output logic                  found,
   output logic [clog2(N)-1:0]   idx,
   output logic [N-1:0]          onehot
);
   localparam int W = clog2(N);

   logic [N-1:0] mask_ge;
   logic [N-1:0] masked;
   logic [N-1:0] src;
   logic [N-1:0] oh;
   logic [W-1:0] idx_c;

   // Two-pass search done in parallel: the upper slice (>= ptr) is preferred,
   // otherwise the whole vector is used, which is the wrapped-around part.
   // Lowest-set-bit isolation (x & -x) keeps the path a single carry chain.
   always_comb begin
      // NOTE: every always_comb output gets a default before any branch so no
      // path leaves it unassigned, which would otherwise infer a latch.
      mask_ge = '0;
      idx_c   = '0;
      for (int i = 0; i < N; i++) mask_ge[i] = (i >= int'(ptr));
      masked = req & mask_ge;
      src    = (masked != '0) ? masked : req;
      oh     = src & (~src + {{(N-1){1'b0}}, 1'b1});
      for (int i = 0; i < N; i++) begin
         if (oh[i]) idx_c = idx_c | W'(i);
      end
   end

   assign found  = (req != '0);
   assign idx    = idx_c;
   assign onehot = oh;

endmodule

// File: rtl/rr_prio_encoder.sv
// Registered N-to-log2(N) request encoder with fixed-priority or round-robin
// arbitration and a valid/ready output register.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : rr_prio_encoder_if.slave (req, out_ready in; out_valid, out_idx,
//         grant, multi out)
// Parameters: N request lines (2..256), MODE = MODE_FIXED or MODE_RR.
module rr_prio_encoder
   import enc_pkg::*;
#(
   parameter int N    = 8,
   parameter int MODE = MODE_FIXED
) (
   input  logic               clk,
   input  logic               rst,
   rr_prio_encoder_if.slave   bus
);
   localparam int W = clog2(N);

   logic         valid_q;
   logic [W-1:0] idx_q;
   logic [N-1:0] grant_q;
   logic         multi_q;
   logic [W-1:0] ptr;

   logic         found;
   logic [W-1:0] win_idx;
   logic [N-1:0] win_oh;
   logic         free;

   rr_pick #(.N(N)) u_pick (
      .req    (bus.req),
      .ptr    (ptr),
      .found  (found),
      .idx    (win_idx),
      .onehot (win_oh)
   );

   // The register may load whenever it is empty or its content leaves this cycle.
   assign free = !valid_q || bus.out_ready;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
         grant_q <= '0;
         multi_q <= 1'b0;
         ptr     <= '0;
      end else if (free) begin
         if (found) begin
            valid_q <= 1'b1;
            idx_q   <= win_idx;
            grant_q <= win_oh;
            multi_q <= popcount_gt1(MAX_N'(bus.req));
            // Explicit wrap at N-1 so non-power-of-2 N never reaches index N.
            if (MODE == MODE_RR)
               ptr <= (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
         end else begin
            // out_idx deliberately keeps its last value when going empty.
            valid_q <= 1'b0;
            grant_q <= '0;
            multi_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_idx   = idx_q;
   assign bus.grant     = grant_q;
   assign bus.multi     = multi_q;

endmodule

// File: tb/tb_rr_prio_encoder.sv
// Bench for rr_prio_encoder: three instances (N=8 fixed, N=8 round-robin,
// N=5 round-robin) share clk/rst. Each has a reference model that pushes the
// expected result into a queue on capture and a monitor that compares the
// queue head against the DUT output every cycle, popping on handshake.
module tb_rr_prio_encoder;
   import enc_pkg::*;

   typedef struct packed {
      int   idx;
      logic multi;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] stim_req  [3];
   logic       stim_rdy  [3];
   logic       obs_valid [3];
   logic [7:0] obs_idx   [3];
   logic [7:0] obs_grant [3];
   logic       obs_multi [3];

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
      vectors++;
      if (act !== req_val) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req_val);
      end
   endtask

   // Winner = first set bit scanning up from ptr with modular wrap.
   function automatic exp_t ref_pick(input int n, input int ptr, input logic [7:0] r);
      exp_t e;
      int   hits;
      e.idx   = -1;
      e.multi = 1'b0;
      hits    = 0;
      for (int k = 0; k < n; k++) begin
         int j;
         j = (ptr + k) % n;
         if (r[j]) begin
            hits++;
            if (e.idx < 0) e.idx = j;
         end
      end
      e.multi = (hits > 1);
      return e;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : u_cfg
      localparam int NN = (g == 2) ? 5 : 8;
      localparam int MM = (g == 0) ? MODE_FIXED : MODE_RR;

      rr_prio_encoder_if #(.N(NN)) bus ();
      rr_prio_encoder #(.N(NN), .MODE(MM)) dut (.clk(clk), .rst(rst), .bus(bus));

      assign bus.req      = stim_req[g][NN-1:0];
      assign bus.out_ready = stim_rdy[g];
      assign obs_valid[g] = bus.out_valid;
      assign obs_idx[g]   = 8'(bus.out_idx);
      assign obs_grant[g] = 8'(bus.grant);
      assign obs_multi[g] = bus.multi;

      exp_t q[$];
      int   m_ptr;
      bit   m_full;

      // Reference model: decides captures from the sampled inputs.
      initial begin
         exp_t e;
         m_ptr  = 0;
         m_full = 1'b0;
         forever begin
            @(posedge clk);
            if (rst) begin
               q.delete();
               m_ptr  = 0;
               m_full = 1'b0;
            end else if (!m_full || bus.out_ready) begin
               if (bus.req != '0) begin
                  e = ref_pick(NN, m_ptr, 8'(bus.req));
                  q.push_back(e);
                  if (MM == MODE_RR) m_ptr = (e.idx + 1) % NN;
                  m_full = 1'b1;
               end else begin
                  m_full = 1'b0;
               end
            end
         end
      end

      // Monitor: compares the presented output against the queue head.
      initial begin
         exp_t       e;
         logic [7:0] eg;
         forever begin
            @(negedge clk);
            if (q.size() == 0) begin
               check($sformatf("c%0d idle valid", g), 32'(bus.out_valid), 32'd0);
               check($sformatf("c%0d idle grant", g), 32'(bus.grant), 32'd0);
               check($sformatf("c%0d idle multi", g), 32'(bus.multi), 32'd0);
            end else begin
               e  = q[0];
               eg = 8'd0;
               eg[e.idx] = 1'b1;
               check($sformatf("c%0d valid", g), 32'(bus.out_valid), 32'd1);
               check($sformatf("c%0d idx", g), 32'(bus.out_idx), 32'(e.idx));
               check($sformatf("c%0d grant", g), 32'(bus.grant), 32'(eg));
               check($sformatf("c%0d multi", g), 32'(bus.multi), 32'(e.multi));
               if (bus.out_ready) void'(q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input int g, input string name, input logic v,
                            input logic [7:0] idx, input logic [7:0] gr, input logic m);
      check({name, " valid"}, 32'(obs_valid[g]), 32'(v));
      check({name, " idx"},   32'(obs_idx[g]),   32'(idx));
      check({name, " grant"}, 32'(obs_grant[g]), 32'(gr));
      check({name, " multi"}, 32'(obs_multi[g]), 32'(m));
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         stim_req[i] = 8'hFF;
         stim_rdy[i] = 1'b1;
      end
      tick();
      tick();
      for (int i = 0; i < 3; i++) check_out(i, "reset", 1'b0, 8'd0, 8'd0, 1'b0);

      // Idle after reset release.
      rst = 1'b0;
      for (int i = 0; i < 3; i++) stim_req[i] = 8'h00;
      for (int k = 0; k < 3; k++) begin
         tick();
         for (int i = 0; i < 3; i++) check_out(i, "idle", 1'b0, 8'd0, 8'd0, 1'b0);
      end

      // Fixed priority.
      stim_req[0] = 8'b1010_0100;
      tick();
      check_out(0, "fixed a4", 1'b1, 8'd2, 8'h04, 1'b1);
      stim_req[0] = 8'h80;
      tick();
      check_out(0, "fixed 80", 1'b1, 8'd7, 8'h80, 1'b0);
      stim_req[0] = 8'h00;
      tick();
      check(("fixed empty valid"), 32'(obs_valid[0]), 32'd0);

      // Round-robin fairness over all-ones.
      stim_req[1] = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         tick();
         check($sformatf("rr seq %0d", k), 32'(obs_idx[1]), 32'(k % 8));
      end

      // Backpressure: hold idx 3 while req wanders; then capture on release.
      stim_req[1] = 8'h08;
      tick();
      check_out(1, "bp load", 1'b1, 8'd3, 8'h08, 1'b0);
      stim_rdy[1] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         stim_req[1] = 8'($urandom);
         tick();
         check_out(1, "bp hold", 1'b1, 8'd3, 8'h08, 1'b0);
      end
      stim_rdy[1] = 1'b1;
      stim_req[1] = 8'h21;
      tick();
      check_out(1, "bp release", 1'b1, 8'd5, 8'h20, 1'b1);

      // Mid-operation reset with a result held and ptr at 6.
      rst = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) check_out(i, "mid reset", 1'b0, 8'd0, 8'd0, 1'b0);
      rst = 1'b0;
      stim_req[1] = 8'hC0;
      tick();
      check_out(1, "post reset c0", 1'b1, 8'd6, 8'h40, 1'b1);
      stim_req[1] = 8'h00;

      // Non-power-of-2 wrap at N=5: move ptr to 1, then alternate 4,0.
      stim_req[2] = 8'h01;
      tick();
      check(("n5 prime idx"), 32'(obs_idx[2]), 32'd0);
      stim_req[2] = 8'h11;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("n5 wrap %0d", k), 32'(obs_idx[2]), (k % 2 == 0) ? 32'd4 : 32'd0);
      end

      // Randomised traffic with random backpressure and rare resets.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 3; i++) begin
            case ($urandom_range(0, 3))
               0:       stim_req[i] = 8'h00;
               1:       stim_req[i] = 8'h01 << $urandom_range(0, 7);
               2:       stim_req[i] = 8'hFF;
               default: stim_req[i] = 8'($urandom);
            endcase
            stim_rdy[i] = ($urandom_range(0, 3) != 0);
         end
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0;
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
